fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch front end that feeds the control unit and the register file decoder.
- Holds the word-addressed PC and issues single-outstanding requests to instruction memory.
- Presents the fetched instruction's fields with a valid/ready handshake.
- Computes the next PC from pc_src, which the control unit returns for the instruction being accepted.

Parameters:
ADDR_W, 32, PC and instruction-memory address width (words)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  ADDR_W  word address of request (= pc)
imem_rsp_valid  in  1  response data valid
imem_rsp_data  in  32  instruction word
instr_valid  out  1  fields below are valid
instr_ready  in  1  decode/execute consumes instruction
instr_pc  out  ADDR_W  PC of presented instruction
opcode  out  6  instr[31:26]
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
shamt  out  5  instr[10:6]
funct  out  6  instr[5:0]
imm  out  16  instr[15:0]
target  out  26  instr[25:0]
pc_src  in  2  next-PC select: 00 branch, 01 jump, 10 register, 11 PC+1
branch_taken  in  1  branch condition result, qualifies pc_src=00
rs_value  in  ADDR_W  register target for pc_src=10 (JR/JALR)
fetch_count  out  32  number of instructions accepted (fires)
fetch_err  out  1  sticky: response received while not in WAIT

Behaviour:
- All field outputs are driven from a 32-bit instruction register (ir). Each field is a bit-slice of ir, MSB first.
- FSM states: IDLE, REQ, WAIT, VALID.
- Reset (rst_n=0, asynchronous) sets:
  - state=IDLE, pc=RESET_PC, ir=0, instr_pc=0.
  - fetch_count=0, fetch_err=0.
  - imem_req_valid=0, instr_valid=0.
- IDLE: always moves to REQ on the next edge, so the first request appears in the first cycle after reset release.
- REQ:
  - imem_req_valid=1, imem_addr=pc.
  - If imem_req_ready=1, go to WAIT. Otherwise hold; address stays stable while waiting.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid=1: ir<=imem_rsp_data, instr_pc<=pc, go to VALID.
  - Responses arrive no earlier than the cycle after acceptance. Any wait length is allowed.
- VALID:
  - instr_valid=1.
  - Fire = instr_valid & instr_ready. On fire: pc<=next_pc, fetch_count+=1, go to REQ. Without fire, hold all outputs.
- next_pc is evaluated only on fire, using the inputs in that cycle:
  - 11: instr_pc+1.
  - 00: branch_taken ? instr_pc+1+sext(imm) : instr_pc+1.
  - 01: {pc_plus1[ADDR_W-1:26], target}.
  - 10: rs_value.
- Arithmetic is modulo 2^ADDR_W, so the PC wraps silently.
- Throughput: the minimum is one instruction per 3 cycles (REQ with ready, WAIT with response the next cycle, VALID with ready).
- A response while the state is not WAIT is dropped and sets fetch_err=1. fetch_err is cleared only by reset.
- imem_rsp_valid and imem_req_ready are ignored in IDLE and VALID except for the fetch_err check.
- Reset mid-operation: an outstanding request is abandoned. A late response after reset release while in IDLE/REQ sets fetch_err.
- fetch_count wraps from 0xFFFFFFFF to 0.
- pc_src, branch_taken and rs_value are don't-care when not firing.

Test Plan:
- Reset with RESET_PC=0x40, memory ready=1 and 1-cycle latency returning 0x2008_0005 (ADDI) -> imem_addr=0x40 in cycle 1; instr_valid in cycle 3 with opcode=0x08, rt=8, imm=5; with pc_src=11 the next request address is 0x41.
- BEQ 0x1000_FFFE at pc=0x10 with pc_src=00: branch_taken=1 -> next addr 0x0F; branch_taken=0 -> next addr 0x11.
- J 0x0800_0100 at pc=0x20, pc_src=01 -> next addr 0x100; JR with pc_src=10 and rs_value=0x1234 -> next addr 0x1234.
- Backpressure: hold imem_req_ready=0 for 5 cycles and then instr_ready=0 for 4 cycles -> address stable, fields stable, fetch_count increments only once per fire.
- Stray imem_rsp_valid pulse in REQ -> fetch_err=1 and stays 1; ir unchanged. Assert rst_n=0 in WAIT -> all outputs return to reset values immediately, with no clock edge needed.
- pc=2^ADDR_W-1 with pc_src=11 -> next addr 0; fetch_count preloaded near wrap via 2^32 fires (or forced) -> wraps to 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding imem requests, instruction
// register with field decode, and next-PC selection on each accepted instruction.
//   state   | meaning
//   S_IDLE  | after reset, issue first request next cycle
//   S_REQ   | request valid, holding pc until memory accepts
//   S_WAIT  | request accepted, waiting for response
//   S_VALID | instruction presented, waiting for consumer
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm,
    output logic [25:0]       target,
    input  logic [1:0]        pc_src,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] rs_value,
    output logic [31:0]       fetch_count,
    output logic              fetch_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_VALID} state_t;

    localparam logic [ADDR_W-1:0] JUMP_MASK = ADDR_W'(64'h0000_0000_03FF_FFFF);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] imm_sext;
    logic [ADDR_W-1:0] next_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ipc_q   <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Jump keeps the upper bits of the sequential PC and splices in the 26-bit target.
    always_comb begin
        pc_plus1 = ipc_q + ADDR_W'(1);
        imm_sext = {{(ADDR_W-16){ir_q[15]}}, ir_q[15:0]};
        next_pc  = pc_plus1;
        case (pc_src)
            2'b00:   next_pc = branch_taken ? (pc_plus1 + imm_sext) : pc_plus1;
            2'b01:   next_pc = (pc_plus1 & ~JUMP_MASK) | (ADDR_W'(ir_q[25:0]) & JUMP_MASK);
            2'b10:   next_pc = rs_value;
            default: next_pc = pc_plus1;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ipc_d          = ipc_q;
        ir_d           = ir_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    ir_d    = imem_rsp_data;
                    ipc_d   = pc_q;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    pc_d    = next_pc;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (imem_rsp_valid && (state_q != S_WAIT)) err_d = 1'b1;
    end

    assign imem_addr   = pc_q;
    assign instr_pc    = ipc_q;
    assign fetch_count = cnt_q;
    assign fetch_err   = err_q;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign imm    = ir_q[15:0];
    assign target = ir_q[25:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized
// instruction transactions against a transaction-level PC/count model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_pc;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [31:0] rs_value;
    logic [31:0] fetch_count;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc, m_cnt, last_d;
    logic        m_err;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h40)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_pc(instr_pc),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target),
        .pc_src(pc_src), .branch_taken(branch_taken), .rs_value(rs_value),
        .fetch_count(fetch_count), .fetch_err(fetch_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] ipc, input logic [31:0] instr,
                                             input logic [1:0] src, input logic bt,
                                             input logic [31:0] rsv);
        logic [31:0] seq;
        seq = ipc + 32'd1;
        if (src == 2'b11) return seq;
        if (src == 2'b00) return bt ? seq + 32'($signed(instr[15:0])) : seq;
        if (src == 2'b01) return {seq[31:26], instr[25:0]};
        return rsv;
    endfunction

    function automatic logic [63:0] fields_of(input logic [31:0] d);
        return {6'd0, d[31:26], d[25:21], d[20:16], d[15:11], d[10:6], d[5:0],
                d[15:0], d[25:0]};
    endfunction

    function automatic logic [63:0] dut_fields();
        return {6'd0, opcode, rs, rt, rd, shamt, funct, imm, target};
    endfunction

    task automatic randomize_dont_cares();
        pc_src       = 2'($urandom_range(0, 3));
        branch_taken = 1'($urandom_range(0, 1));
        rs_value     = $urandom;
        imem_rsp_data = $urandom;
    endtask

    task automatic run_instr(input logic [31:0] d, input logic [1:0] src, input logic bt,
                             input logic [31:0] rsv, input int req_stall, input int lat,
                             input int rdy_stall);
        int n;
        logic [31:0] ipc;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 64'(imem_req_valid), 64'd1);
        if (!imem_req_valid) return;
        chk("req_addr", 64'(imem_addr), 64'(m_pc));
        for (int i = 0; i < req_stall; i++) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b0;
            @(negedge clk);
            chk("req_hold", {31'd0, imem_req_valid, imem_addr}, {31'd0, 1'b1, m_pc});
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'($urandom_range(0, 1));
        chk("wait_no_req", 64'(imem_req_valid), 64'd0);
        for (int i = 1; i < lat; i++) @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        imem_req_ready = 1'($urandom_range(0, 1));
        chk("rsp_to_valid", 64'(instr_valid), 64'd1);
        ipc = m_pc;
        chk("fields", dut_fields(), fields_of(d));
        chk("instr_pc", 64'(instr_pc), 64'(ipc));
        for (int i = 0; i < rdy_stall; i++) begin
            instr_ready = 1'b0;
            randomize_dont_cares();
            @(negedge clk);
            chk("valid_hold", {31'd0, instr_valid, fetch_count}, {31'd0, 1'b1, m_cnt});
            chk("fields_hold", dut_fields(), fields_of(d));
        end
        instr_ready  = 1'b1;
        pc_src       = src;
        branch_taken = bt;
        rs_value     = rsv;
        m_pc  = ref_next(ipc, d, src, bt, rsv);
        m_cnt = m_cnt + 32'd1;
        last_d = d;
        @(negedge clk);
        instr_ready = 1'b0;
        randomize_dont_cares();
        chk("count", 64'(fetch_count), 64'(m_cnt));
        chk("next_addr", {31'd0, imem_req_valid, imem_addr}, {31'd0, 1'b1, m_pc});
        chk("err", 64'(fetch_err), 64'(m_err));
    endtask

    task automatic model_reset();
        m_pc  = 32'h40;
        m_cnt = 32'd0;
        m_err = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        instr_ready    = 1'b0;
        pc_src         = 2'b11;
        branch_taken   = 1'b0;
        rs_value       = 32'd0;
        last_d         = 32'd0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_outputs", {30'd0, imem_req_valid, instr_valid, fetch_err, fetch_count},
            64'd0);
        chk("rst_ir_pc", {instr_pc, opcode, rs, rt, rd, shamt, funct}, 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'h40);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req_cycle", {31'd0, imem_req_valid, imem_addr}, {31'd0, 1'b1, 32'h40});

        run_instr(32'h2008_0005, 2'b11, 1'b0, 32'd0, 0, 1, 0);
        chk("addi_next", 64'(imem_addr), 64'h41);
        chk("addi_opcode", {opcode, rt, imm}, {6'h08, 5'd8, 16'd5});

        run_instr(32'h0000_0008, 2'b10, 1'b0, 32'h10, 0, 1, 0);
        run_instr(32'h1000_FFFE, 2'b00, 1'b1, 32'd0, 0, 2, 0);
        chk("beq_taken", 64'(imem_addr), 64'h0F);
        run_instr(32'h0000_0008, 2'b10, 1'b0, 32'h10, 1, 1, 1);
        run_instr(32'h1000_FFFE, 2'b00, 1'b0, 32'd0, 0, 1, 0);
        chk("beq_not_taken", 64'(imem_addr), 64'h11);
        run_instr(32'h0000_0008, 2'b10, 1'b0, 32'h20, 0, 1, 0);
        run_instr(32'h0800_0100, 2'b01, 1'b0, 32'd0, 0, 3, 0);
        chk("jump", 64'(imem_addr), 64'h100);
        run_instr(32'h0320_0008, 2'b10, 1'b0, 32'h1234, 0, 1, 0);
        chk("jr", 64'(imem_addr), 64'h1234);

        // Backpressure on both sides.
        run_instr(32'h8C43_0010, 2'b11, 1'b0, 32'd0, 5, 4, 4);
        chk("bp_count", 64'(fetch_count), 64'd9);

        // Stray response while requesting: flagged, dropped.
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        m_err = 1'b1;
        chk("stray_err", 64'(fetch_err), 64'd1);
        chk("stray_ir_kept", dut_fields(), fields_of(last_d));

        // PC wrap.
        run_instr(32'h0000_0008, 2'b10, 1'b0, 32'hFFFF_FFFF, 0, 1, 0);
        run_instr(32'h0000_0000, 2'b11, 1'b0, 32'd0, 0, 1, 0);
        chk("pc_wrap", 64'(imem_addr), 64'h0);
        chk("err_sticky", 64'(fetch_err), 64'd1);

        // Asynchronous reset while waiting for a response.
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {30'd0, imem_req_valid, instr_valid, fetch_err, fetch_count},
            64'd0);
        chk("async_rst_pc", {imem_addr, instr_pc}, {32'h40, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        imem_rsp_valid = 1'b1;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        m_err = 1'b1;
        chk("late_rsp_err", 64'(fetch_err), 64'd1);
        chk("late_rsp_req", {31'd0, imem_req_valid, imem_addr}, {31'd0, 1'b1, 32'h40});

        for (int k = 0; k < 200; k++) begin
            run_instr($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                      $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
